// File: rtl/digit_scan_driver.sv
// Scans a DIGITS-wide hex value onto a shared nibble bus with one-hot digit enables.
// Build option DIGIT_SCAN_LZ_BLANK_EN enables leading-zero suppression.
module digit_scan_driver #(
    parameter int DIGITS   = 4,
    parameter int PRESCALE = 1000,
    parameter int BLANK    = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [4*DIGITS-1:0] value_in,
    input  logic [DIGITS-1:0]   dp_in,
    input  logic                load,
    output logic [3:0]          bcd,
    output logic [DIGITS-1:0]   digit_en,
    output logic                dp,
    output logic                frame_done
);

    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(PRESCALE - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

    logic [CW-1:0]       cnt;
    logic [IW-1:0]       idx;
    logic [4*DIGITS-1:0] disp_val, pend_val;
    logic [DIGITS-1:0]   disp_dp, pend_dp;
    logic                pend_vld;

    logic slot_end, wrap, show, suppress;

    // load is a one-cycle strobe with no back-pressure: it is always accepted,
    // either straight into the display (wrap cycle) or into the pending buffer.
    assign slot_end = (cnt == CNT_LAST);
    assign wrap     = slot_end && (idx == IDX_LAST);

`ifdef DIGIT_SCAN_LZ_BLANK_EN
    always_comb begin
        logic upper_zero;
        upper_zero = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            if (k >= int'(idx) && disp_val[4*k +: 4] != 4'h0) upper_zero = 1'b0;
        end
        suppress = (idx != '0) && upper_zero;
    end
`else
    assign suppress = 1'b0;
`endif

    assign show = (int'(cnt) >= BLANK) && !suppress;

    // Output decode from registers only; no path from inputs.
    always_comb begin
        bcd      = 4'h0;
        dp       = 1'b0;
        digit_en = '0;
        for (int k = 0; k < DIGITS; k++) begin
            if (idx == IW'(k)) begin
                bcd         = disp_val[4*k +: 4];
                dp          = disp_dp[k] && !suppress;
                digit_en[k] = show;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            idx        <= '0;
            disp_val   <= '0;
            disp_dp    <= '0;
            pend_val   <= '0;
            pend_dp    <= '0;
            pend_vld   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= wrap;
            if (slot_end) begin
                cnt <= '0;
                idx <= wrap ? '0 : idx + IW'(1);
            end else begin
                cnt <= cnt + CW'(1);
            end
            // A load on the wrap cycle bypasses and discards any pending value.
            if (wrap) begin
                if (load) begin
                    disp_val <= value_in;
                    disp_dp  <= dp_in;
                end else if (pend_vld) begin
                    disp_val <= pend_val;
                    disp_dp  <= pend_dp;
                end
                pend_vld <= 1'b0;
            end else if (load) begin
                pend_val <= value_in;
                pend_dp  <= dp_in;
                pend_vld <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_digit_scan_driver.sv
// Directed bench for digit_scan_driver with DIGITS=4, PRESCALE=4, BLANK=1 (16-cycle frame).
module tb_digit_scan_driver;
    localparam int DIGITS   = 4;
    localparam int PRESCALE = 4;
    localparam int BLANK    = 1;

`ifdef DIGIT_SCAN_LZ_BLANK_EN
    localparam logic [3:0] ZMASK = 4'b0001;
    localparam logic [3:0] M42   = 4'b0011;
`else
    localparam logic [3:0] ZMASK = 4'b1111;
    localparam logic [3:0] M42   = 4'b1111;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] value_in = '0;
    logic [3:0]  dp_in = '0;
    logic        load = 1'b0;
    logic [3:0]  bcd;
    logic [3:0]  digit_en;
    logic        dp;
    logic        frame_done;

    int tests = 0;
    int fails = 0;

    // digit_en per cycle of one frame: blank guard cycle, then three lit cycles
    logic [3:0] en_tab [16] = '{4'b0000, 4'b0001, 4'b0001, 4'b0001,
                                4'b0000, 4'b0010, 4'b0010, 4'b0010,
                                4'b0000, 4'b0100, 4'b0100, 4'b0100,
                                4'b0000, 4'b1000, 4'b1000, 4'b1000};

    digit_scan_driver #(.DIGITS(DIGITS), .PRESCALE(PRESCALE), .BLANK(BLANK)) dut (
        .clk(clk), .rst_n(rst_n), .value_in(value_in), .dp_in(dp_in), .load(load),
        .bcd(bcd), .digit_en(digit_en), .dp(dp), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
        tests++;
        assert (obs === exp_v) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs ncyc cycles of a frame, checking outputs each cycle and pulsing load at cycles la/lb.
    task automatic run_frame(input string name, input int ncyc, input bit first,
                             input logic [15:0] exp_val, input logic [3:0] exp_dp,
                             input logic [3:0] mask,
                             input int la, input logic [15:0] va, input logic [3:0] da,
                             input int lb, input logic [15:0] vb, input logic [3:0] db);
        int s;
        for (int c = 0; c < ncyc; c++) begin
            s = c / 4;
            load = 1'b0;
            if (c == la) begin
                load = 1'b1; value_in = va; dp_in = da;
            end else if (c == lb) begin
                load = 1'b1; value_in = vb; dp_in = db;
            end
            chk($sformatf("%s c%0d bcd", name, c), {12'h0, bcd}, {12'h0, exp_val[4*s +: 4]});
            chk($sformatf("%s c%0d digit_en", name, c), {12'h0, digit_en}, {12'h0, en_tab[c] & mask});
            chk($sformatf("%s c%0d dp", name, c), {15'h0, dp}, {15'h0, exp_dp[s] & mask[s]});
            chk($sformatf("%s c%0d frame_done", name, c), {15'h0, frame_done},
                {15'h0, (c == 0) && !first});
            tick();
        end
        load = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset bcd", {12'h0, bcd}, 16'h0);
        chk("reset digit_en", {12'h0, digit_en}, 16'h0);
        chk("reset dp", {15'h0, dp}, 16'h0);
        chk("reset frame_done", {15'h0, frame_done}, 16'h0);
        rst_n = 1'b1;

        // Frame 0: blank display, load 12AF mid-frame (must not show yet)
        run_frame("f0", 16, 1'b1, 16'h0000, 4'b0000, ZMASK, 5, 16'h12AF, 4'b0010, -1, 16'h0, 4'h0);
        // Frame 1: 12AF shown, load 0042 on the wrap cycle
        run_frame("f1", 16, 1'b0, 16'h12AF, 4'b0010, 4'b1111, 15, 16'h0042, 4'b0000, -1, 16'h0, 4'h0);
        // Frame 2: 0042 shown, two loads, last one wins
        run_frame("f2", 16, 1'b0, 16'h0042, 4'b0000, M42, 2, 16'h1111, 4'b1111, 9, 16'h2222, 4'b0000);
        run_frame("f3", 16, 1'b0, 16'h2222, 4'b0000, 4'b1111, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);
        // Frame 4: load 1234 pending, then reset at cycle 9
        run_frame("f4", 9, 1'b0, 16'h2222, 4'b0000, 4'b1111, 2, 16'h1234, 4'b1111, -1, 16'h0, 4'h0);

        rst_n = 1'b0;
        #1;
        chk("midreset bcd", {12'h0, bcd}, 16'h0);
        chk("midreset digit_en", {12'h0, digit_en}, 16'h0);
        chk("midreset dp", {15'h0, dp}, 16'h0);
        chk("midreset frame_done", {15'h0, frame_done}, 16'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Pending 1234 must be gone after reset
        run_frame("f5", 16, 1'b1, 16'h0000, 4'b0000, ZMASK, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);
        run_frame("f6", 16, 1'b0, 16'h0000, 4'b0000, ZMASK, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/digit_scan_driver.md
Name: digit_scan_driver

Overview:
- Time-multiplexes a multi-digit hex value onto one shared 4-bit nibble bus that feeds the seven-segment decoder.
- Drives a one-hot digit-enable vector alongside the nibble.
- Sits directly upstream of the decoder: the decoder converts `bcd` to segment patterns, and this block selects which digit is lit.
- New display values are double-buffered and only take effect at frame boundaries, so a partially updated value is never shown.

Parameters:
- DIGITS, 4, number of display digits scanned (1..8).
- PRESCALE, 1000, clock cycles per digit slot (>= 2).
- BLANK, 1, guard cycles at the start of each slot with all digit enables low (0..PRESCALE-1).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- value_in  input  4*DIGITS  new display value; nibble k drives digit k, digit 0 is least significant.
- dp_in  input  DIGITS  decimal-point flags, one per digit.
- load  input  1  single-cycle request to adopt value_in/dp_in.
- bcd  output  4  nibble of the currently selected digit, to the decoder.
- digit_en  output  DIGITS  one-hot active-high digit enable.
- dp  output  1  decimal point of the currently selected digit.
- frame_done  output  1  one-cycle pulse in the first cycle of each new frame.

Behaviour:
- One clock; reset is asynchronous and active-low. rst_n low immediately clears every register.
- State registers:
  - cnt: slot counter, 0..PRESCALE-1.
  - idx: digit index, 0..DIGITS-1.
  - disp_val, disp_dp: displayed value and decimal points.
  - pend_val, pend_dp, pend_vld: pending value, decimal points and valid flag.
  - frame_done register.
- Reset values:
  - cnt=0, idx=0, disp_val=0, disp_dp=0, pend_vld=0, frame_done=0.
  - Hence bcd=0, dp=0, frame_done=0.
  - digit_en=0 if BLANK>0, otherwise 1 (digit 0 enabled).
- Outputs are decoded from registers only (no input-to-output combinational path):
  - bcd = disp_val[4*idx +: 4]; dp = disp_dp[idx].
  - digit_en has bit idx set when cnt >= BLANK; otherwise it is all zeros.
- Counting:
  - cnt increments every cycle.
  - At cnt==PRESCALE-1: cnt returns to 0 and idx increments.
- Wrap cycle is defined as cnt==PRESCALE-1 and idx==DIGITS-1. On the wrap cycle:
  - idx returns to 0.
  - frame_done is set for exactly the next cycle.
  - If load=1 that same cycle: disp_val/disp_dp take value_in/dp_in directly and pend_vld clears (any older pending value is discarded).
  - Else if pend_vld=1: disp takes pend, and pend_vld clears.
- Non-wrap cycle with load=1: pend takes value_in/dp_in and pend_vld sets. A later load in the same frame overwrites it, so the last load wins.
- Latency:
  - A load lands in the frame that starts after the next wrap.
  - Worst case is DIGITS*PRESCALE cycles; best case is 1 cycle (load on the wrap cycle).
- frame_done never pulses out of reset; the first pulse follows the first wrap.
- At most one digit_en bit is high in any cycle.
- rst_n asserted mid-frame: outputs return to reset values asynchronously and the pending value is lost. Scanning restarts at digit 0, cnt 0 on the first edge after release.

Optional Feature:
- Macro: DIGIT_SCAN_LZ_BLANK_EN.
- When defined: leading-zero suppression.
  - In a slot where every nibble of disp_val at positions >= idx is zero and idx>0, digit_en stays all-zero for the whole slot.
  - Digit 0 always displays, so a value of 0 shows a single "0".
  - dp is forced to 0 in suppressed slots.
- When undefined: all digits are enabled per the normal blanking rule, zeros included.

Test Plan (DIGITS=4, PRESCALE=4, BLANK=1, frame=16 cycles; cycle 0 = first edge after reset release):
- Reset, then run 16 cycles:
  - bcd=0 and dp=0 throughout.
  - digit_en: 0000 at cycles 0,4,8,12; 0001 at cycles 1-3; 0010 at 5-7; 0100 at 9-11; 1000 at 13-15.
  - frame_done=1 only at cycle 16.
- load with value_in=16'h12AF at cycle 5:
  - bcd stays 0 through cycle 15.
  - Frame starting at cycle 16: bcd=F, A, 2, 1 in slots 0-3.
- load with 16'h0042 exactly at cycle 15 (the wrap cycle) → bcd=2 from cycle 16, 4 from cycle 20.
- Two loads in one frame:
  - load 16'h1111 at cycle 2, then 16'h2222 at cycle 9.
  - Next frame shows only 2 on every digit; pend_vld is clear afterwards.
- rst_n low at cycle 9 after loading 16'h1234 (pending):
  - Outputs are 0 in the same cycle.
  - After release, the display stays 0 (pending value discarded).
- With DIGIT_SCAN_LZ_BLANK_EN defined:
  - Value 16'h0042: digit_en[3:2] never assert.
  - Value 16'h0000: only digit 0 enables, with bcd=0.
